// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: opcodes, instruction field offsets, flag register
// layout and FSM encoding shared by the datapath sequencer.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0001;
  localparam logic [3:0] OP_BRF  = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b0011;

  localparam logic [1:0] FS_ZERO  = 2'b00;
  localparam logic [1:0] FS_NEG   = 2'b01;
  localparam logic [1:0] FS_CARRY = 2'b10;
  localparam logic [1:0] FS_OV    = 2'b11;

  localparam int F_OP   = 12;
  localparam int F_DST  = 9;
  localparam int F_SRCA = 6;
  localparam int F_SRCB = 3;
  localparam int F_SR   = 0;

  typedef struct packed {
    logic ov;
    logic carry;
    logic neg;
    logic zero;
  } flags_t;

  function automatic logic flag_sel(
    input flags_t     f,
    input logic [1:0] s
  );
    logic r;
    unique case (s)
      FS_ZERO:  r = f.zero;
      FS_NEG:   r = f.neg;
      FS_CARRY: r = f.carry;
      FS_OV:    r = f.ov;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// datapath_ctrl_decode: combinational instruction decode into datapath
// selects, one-hot write mask and control-flow class.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 3
) (
  input  logic [15:0]  ir_i,
  output logic [P-1:0] multa_o,
  output logic [P-1:0] multb_o,
  output logic [1:0]   alu_o,
  output logic [1:0]   sr_o,
  output logic [N-1:0] wmask_o,
  output logic         we_o,
  output logic         is_alu_o,
  output logic         is_jmp_o,
  output logic         is_brf_o,
  output logic         is_halt_o,
  output logic         illegal_o
);

  logic [3:0] op;
  logic [2:0] dst;
  logic       dst_ok;
  logic       unused_bit;

  assign op         = ir_i[F_OP +: 4];
  assign dst        = ir_i[F_DST +: 3];
  assign dst_ok     = int'(dst) < N;
  assign unused_bit = ir_i[2];

  always_comb begin
    multa_o   = '0;
    multb_o   = '0;
    alu_o     = '0;
    sr_o      = '0;
    wmask_o   = '0;
    we_o      = 1'b0;
    is_alu_o  = 1'b0;
    is_jmp_o  = 1'b0;
    is_brf_o  = 1'b0;
    is_halt_o = 1'b0;
    illegal_o = 1'b0;
    unique case (1'b1)
      op[3]: begin
        is_alu_o  = 1'b1;
        multa_o   = P'(ir_i[F_SRCA +: 3]);
        multb_o   = P'(ir_i[F_SRCB +: 3]);
        alu_o     = op[1:0];
        sr_o      = ir_i[F_SR +: 2];
        // out-of-range destination degrades to a flag-only op
        we_o      = op[2] & dst_ok;
        illegal_o = op[2] & ~dst_ok;
        if (we_o) wmask_o = N'(1) << dst;
      end
      op[3:2] == 2'b01: illegal_o = 1'b1;
      op == OP_JMP:     is_jmp_o  = 1'b1;
      op == OP_BRF:     is_brf_o  = 1'b1;
      op == OP_HALT:    is_halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: fetch/exec/writeback sequencer for the MxN datapath;
// owns the FSM, pc, instruction register and flag register.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int P  = 3,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  output logic [P-1:0]  selection_multa,
  output logic [P-1:0]  selection_multb,
  output logic [1:0]    selection_alu,
  output logic [1:0]    selection_sr,
  output logic [N-1:0]  writer,
  input  logic          fov,
  input  logic          fcarry,
  input  logic          fneg,
  input  logic          fzero,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  flags_t        flg_q, flg_d;

  logic [P-1:0]  d_multa, d_multb;
  logic [1:0]    d_alu, d_sr;
  logic [N-1:0]  d_wmask;
  logic          d_we, d_alu_op, d_jmp, d_brf;
  logic          d_halt, d_ill, take;

  datapath_ctrl_decode #(
    .N (N),
    .P (P)
  ) u_decode (
    .ir_i      (ir_q),
    .multa_o   (d_multa),
    .multb_o   (d_multb),
    .alu_o     (d_alu),
    .sr_o      (d_sr),
    .wmask_o   (d_wmask),
    .we_o      (d_we),
    .is_alu_o  (d_alu_op),
    .is_jmp_o  (d_jmp),
    .is_brf_o  (d_brf),
    .is_halt_o (d_halt),
    .illegal_o (d_ill)
  );

  // branches test the registered flags, never the live ALU flags
  assign take = d_jmp | (d_brf &
    (flag_sel(flg_q, ir_q[F_DST+1 +: 2]) == ir_q[F_DST]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    flg_d           = flg_q;
    imem_req        = 1'b0;
    selection_multa = '0;
    selection_multb = '0;
    selection_alu   = '0;
    selection_sr    = '0;
    writer          = '0;
    illegal         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        selection_multa = d_multa;
        selection_multb = d_multb;
        selection_alu   = d_alu;
        selection_sr    = d_sr;
        illegal         = d_ill;
        if (d_alu_op) flg_d = {fov, fcarry, fneg, fzero};
        pc_d = take ? ir_q[AW-1:0] : pc_q + AW'(1);
        if (d_halt) begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end else if (d_we) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        selection_multa = d_multa;
        selection_multb = d_multb;
        selection_alu   = d_alu;
        selection_sr    = d_sr;
        writer          = d_wmask;
        state_d         = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign busy      = (state_q == ST_FETCH) |
                     (state_q == ST_EXEC) |
                     (state_q == ST_WB);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed sequencer bench with an instruction memory
// responder and fetch/write scoreboards.
module tb_datapath_ctrl;

  localparam int N  = 6;
  localparam int P  = 3;
  localparam int AW = 8;

  logic          clk, rst, start;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [P-1:0]  selection_multa, selection_multb;
  logic [1:0]    selection_alu, selection_sr;
  logic [N-1:0]  writer;
  logic          fov, fcarry, fneg, fzero;
  logic          busy, halted, illegal;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;
  int efetch[$];
  int ewrite[$];
  logic [15:0] mem [0:255];

  datapath_ctrl #(
    .N  (N),
    .P  (P),
    .AW (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .selection_multa (selection_multa),
    .selection_multb (selection_multb),
    .selection_alu   (selection_alu),
    .selection_sr    (selection_sr),
    .writer          (writer),
    .fov             (fov),
    .fcarry          (fcarry),
    .fneg            (fneg),
    .fzero           (fzero),
    .busy            (busy),
    .halted          (halted),
    .illegal         (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [3:0] op,
    input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
    input logic [1:0] sr);
    return {op, d, a, b, 1'b0, sr};
  endfunction

  function automatic logic [15:0] brf(input logic [1:0] fs,
    input logic v, input logic [7:0] t);
    return {4'b0010, fs, v, 1'b0, t};
  endfunction

  // memory responder: acks after ack_delay waiting cycles, scores fetch addr
  initial begin
    int wcnt;
    int exp;
    wcnt      = 0;
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && imem_req === 1'b1) begin
        if (wcnt >= ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          wcnt      = 0;
          exp = (efetch.size() > 0) ? efetch.pop_front() : 32'hDEAD;
          chk("fetch_addr", 32'(imem_addr), exp);
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // write monitor: every nonzero writer must match the next expected mask
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && writer !== '0) begin
        exp = (ewrite.size() > 0) ? ewrite.pop_front() : 0;
        chk("write_mask", 32'(writer), exp);
      end
    end
  end

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(halted), 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    {fov, fcarry, fneg, fzero} = 4'b0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_writer", 32'(writer), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_illegal", 32'(illegal), 0);
    rst = 1'b1;

    // reset asserted in the middle of a writeback cycle
    mem[0] = alu(4'b1101, 3'd2, 3'd1, 3'd2, 2'b00);
    mem[1] = 16'h3000;
    efetch.push_back(0);
    ewrite.push_back(32'h04);
    run_start();
    @(negedge clk);
    @(negedge clk);
    chk("t1_wb_writer", 32'(writer), 32'h04);
    #1 rst = 1'b0;
    #1;
    chk("t1_async_writer", 32'(writer), 0);
    chk("t1_async_req", 32'(imem_req), 0);
    chk("t1_async_busy", 32'(busy), 0);
    chk("t1_async_alu", 32'(selection_alu), 0);
    efetch.delete();
    ewrite.delete();
    @(negedge clk);
    rst = 1'b1;

    // ALU write with immediate ack
    mem[0] = alu(4'b1101, 3'd3, 3'd0, 3'd1, 2'b10);
    mem[1] = 16'h3000;
    efetch.push_back(0);
    efetch.push_back(1);
    ewrite.push_back(32'h08);
    run_start();
    chk("t2_req", 32'(imem_req), 1);
    chk("t2_addr0", 32'(imem_addr), 0);
    @(negedge clk);
    chk("t2_exec_alu", 32'(selection_alu), 1);
    chk("t2_exec_multa", 32'(selection_multa), 0);
    chk("t2_exec_multb", 32'(selection_multb), 1);
    chk("t2_exec_sr", 32'(selection_sr), 2);
    chk("t2_exec_writer", 32'(writer), 0);
    @(negedge clk);
    chk("t2_wb_alu", 32'(selection_alu), 1);
    chk("t2_wb_multb", 32'(selection_multb), 1);
    chk("t2_wb_writer", 32'(writer), 32'h08);
    @(negedge clk);
    chk("t2_req2", 32'(imem_req), 1);
    chk("t2_addr1", 32'(imem_addr), 1);
    wait_halt("t2_halt");
    chk("t2_halt_req", 32'(imem_req), 0);
    chk("t2_halt_busy", 32'(busy), 0);

    // delayed ack: request and address held steady
    ack_delay = 4;
    mem[0] = alu(4'b1110, 3'd2, 3'd4, 3'd5, 2'b01);
    efetch.push_back(0);
    efetch.push_back(1);
    ewrite.push_back(32'h04);
    run_start();
    for (int i = 0; i < 5; i++) begin
      chk("t3_req", 32'(imem_req), 1);
      chk("t3_addr", 32'(imem_addr), 0);
      chk("t3_alu", 32'(selection_alu), 0);
      @(negedge clk);
    end
    chk("t3_exec_alu", 32'(selection_alu), 2);
    chk("t3_exec_multa", 32'(selection_multa), 4);
    chk("t3_exec_multb", 32'(selection_multb), 5);
    wait_halt("t3_halt");
    ack_delay = 0;

    // compare then conditional branches on each flag
    {fov, fcarry, fneg, fzero} = 4'b0101;
    mem[0]     = alu(4'b1001, 3'd5, 3'd2, 3'd3, 2'b00);
    mem[1]     = brf(2'b00, 1'b1, 8'h40);
    mem[8'h40] = brf(2'b00, 1'b0, 8'h80);
    mem[8'h41] = brf(2'b10, 1'b1, 8'h50);
    mem[8'h50] = brf(2'b11, 1'b1, 8'h90);
    mem[8'h51] = 16'h3000;
    foreach (efetch[i]) efetch.delete(i);
    efetch = '{0, 1, 8'h40, 8'h41, 8'h50, 8'h51};
    run_start();
    chk("t4_addr0", 32'(imem_addr), 0);
    @(negedge clk);
    chk("t4_cmp_alu", 32'(selection_alu), 1);
    chk("t4_cmp_writer", 32'(writer), 0);
    @(negedge clk);
    chk("t4_cmp_next_req", 32'(imem_req), 1);
    chk("t4_cmp_next_addr", 32'(imem_addr), 1);
    wait_halt("t4_halt");

    // live neg=1 but registered neg=0: branch must fall through
    fneg = 1'b1;
    mem[0] = brf(2'b01, 1'b1, 8'h60);
    mem[1] = 16'h3000;
    efetch = '{0, 1};
    run_start();
    wait_halt("t4_reg_halt");
    {fov, fcarry, fneg, fzero} = 4'b0000;

    // illegal opcode, out-of-range dst, then a valid write and a jump
    mem[0]     = 16'h4000;
    mem[1]     = alu(4'b1100, 3'd7, 3'd1, 3'd2, 2'b00);
    mem[2]     = alu(4'b1100, 3'd5, 3'd1, 3'd2, 2'b00);
    mem[3]     = {4'b0001, 4'b0000, 8'h20};
    mem[8'h20] = 16'h3000;
    efetch = '{0, 1, 2, 3, 8'h20};
    ewrite.push_back(32'h20);
    run_start();
    @(negedge clk);
    chk("t5_ill_op", 32'(illegal), 1);
    chk("t5_ill_op_writer", 32'(writer), 0);
    @(negedge clk);
    chk("t5_ill_pulse", 32'(illegal), 0);
    chk("t5_addr1", 32'(imem_addr), 1);
    @(negedge clk);
    chk("t5_ill_dst", 32'(illegal), 1);
    chk("t5_ill_dst_writer", 32'(writer), 0);
    @(negedge clk);
    chk("t5_no_wb_req", 32'(imem_req), 1);
    chk("t5_no_wb_addr", 32'(imem_addr), 2);
    chk("t5_ill_clear", 32'(illegal), 0);
    wait_halt("t5_halt");

    // pc wrap 0xFF -> 0x00, halt hold, restart from 0
    fzero = 1'b1;
    mem[0]     = brf(2'b00, 1'b0, 8'hFE);
    mem[8'hFE] = alu(4'b1001, 3'd0, 3'd0, 3'd0, 2'b00);
    mem[8'hFF] = 16'h0000;
    mem[1]     = 16'h3000;
    efetch = '{0, 8'hFE, 8'hFF, 0, 1};
    run_start();
    wait_halt("t6_halt");
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_halted", 32'(halted), 1);
      chk("t6_hold_req", 32'(imem_req), 0);
    end
    mem[0] = 16'h3000;
    efetch = '{0};
    run_start();
    chk("t6_restart_req", 32'(imem_req), 1);
    chk("t6_restart_addr", 32'(imem_addr), 0);
    wait_halt("t6_restart_halt");

    chk("fetch_queue_empty", 32'(efetch.size()), 0);
    chk("write_queue_empty", 32'(ewrite.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
